// File: rtl/motor_cmd_sequencer.sv
// Turns opcode/duration commands into timed {In1,In2,In3,In4} drive segments,
// inserting an all-zero coast interval whenever one drive pattern replaces another.
module motor_cmd_sequencer #(
  parameter int DUR_W       = 16,
  parameter int DEAD_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic             abort,
  output logic [3:0]       dir_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = (DUR_W > 8) ? DUR_W : 8;
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DEAD, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       pend_pat;
  logic [DUR_W-1:0] pend_len;
  logic             err_done;   // reserved-opcode done pulse lags err by one cycle

  logic [3:0]       new_pat;
  logic [DUR_W-1:0] len_m1;
  logic             need_dead;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    new_pat = 4'b0000;
    case (cmd_op)
      3'd1:    new_pat = 4'b1010;
      3'd2:    new_pat = 4'b0101;
      3'd3:    new_pat = 4'b1000;
      3'd4:    new_pat = 4'b0010;
      3'd5:    new_pat = 4'b0100;
      3'd6:    new_pat = 4'b0001;
      default: new_pat = 4'b0000;
    endcase
  end

  assign len_m1    = (cmd_dur == '0) ? '0 : cmd_dur - DUR_W'(1);
  assign need_dead = (dir_out != 4'b0000) && (new_pat != dir_out) && (new_pat != 4'b0000);
  assign cmd_ready = rst_n && (state == IDLE) && !abort;
  assign busy      = (state != IDLE);

  // NOTE: all state here is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dir_out  <= 4'b0000;
      pend_pat <= 4'b0000;
      pend_len <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_done <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      cnt      <= '0;
      dir_out  <= 4'b0000;
      done     <= 1'b0;
      err      <= 1'b0;
      err_done <= 1'b0;
    end else begin
      done     <= err_done;
      err      <= 1'b0;
      err_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_op == 3'd7) begin
              err      <= 1'b1;
              err_done <= 1'b1;
            end else if (need_dead) begin
              dir_out  <= 4'b0000;
              state    <= DEAD;
              cnt      <= DEAD_LOAD;
              pend_pat <= new_pat;
              pend_len <= len_m1;
            end else begin
              dir_out  <= new_pat;
              state    <= RUN;
              cnt      <= CNT_W'(len_m1);
            end
          end
        end
        DEAD: begin
          if (cnt == '0) begin
            dir_out <= pend_pat;
            state   <= RUN;
            cnt     <= CNT_W'(pend_len);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed bench for motor_cmd_sequencer (DUR_W=16, DEAD_CYCLES=8); outputs are
// sampled 1ns after each rising edge and inputs are changed at the same point.
module tb_motor_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_dur;
  logic        abort;
  logic [3:0]  dir_out;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  motor_cmd_sequencer #(.DUR_W(16), .DEAD_CYCLES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dur   (cmd_dur),
    .abort     (abort),
    .dir_out   (dir_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] d, input logic b, input logic dn);
    check({tag, ".dir"},  16'(dir_out), 16'(d));
    check({tag, ".busy"}, 16'(busy),    16'(b));
    check({tag, ".done"}, 16'(done),    16'(dn));
  endtask

  task automatic offer(input logic [2:0] op, input logic [15:0] dur);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dur   = dur;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_dur   = 16'd0;
    abort     = 1'b0;
    #1;
    chk_out("reset", 4'b0000, 1'b0, 1'b0);
    check("reset.err",   16'(err),       16'd0);
    check("reset.ready", 16'(cmd_ready), 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_reset.ready", 16'(cmd_ready), 16'd1);

    // FWD dur=5 from coast: pattern one edge after accept, held 5 cycles
    offer(3'd1, 16'd5);
    step();
    cmd_valid = 1'b0;
    chk_out("fwd5.c1", 4'b1010, 1'b1, 1'b0);
    check("fwd5.ready", 16'(cmd_ready), 16'd0);
    for (int i = 2; i <= 5; i++) begin
      step();
      chk_out($sformatf("fwd5.c%0d", i), 4'b1010, 1'b1, 1'b0);
    end
    step();
    chk_out("fwd5.done", 4'b1010, 1'b0, 1'b1);
    check("fwd5.ready_back", 16'(cmd_ready), 16'd1);
    step();
    chk_out("fwd5.hold", 4'b1010, 1'b0, 1'b0);

    // REV dur=3 over FWD: 8 coast cycles then 3 drive cycles
    offer(3'd2, 16'd3);
    for (int i = 1; i <= 8; i++) begin
      step();
      cmd_valid = 1'b0;
      chk_out($sformatf("rev.dead%0d", i), 4'b0000, 1'b1, 1'b0);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_out($sformatf("rev.run%0d", i), 4'b0101, 1'b1, 1'b0);
    end
    step();
    chk_out("rev.done", 4'b0101, 1'b0, 1'b1);

    // FWD dur=4 offered in the done cycle (dead time from REV), then FWD dur=4 seamlessly
    offer(3'd1, 16'd4);
    for (int i = 1; i <= 8; i++) begin
      step();
      cmd_valid = 1'b0;
      chk_out($sformatf("fwdA.dead%0d", i), 4'b0000, 1'b1, 1'b0);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_out($sformatf("fwdA.run%0d", i), 4'b1010, 1'b1, 1'b0);
    end
    step();
    chk_out("fwdA.done", 4'b1010, 1'b0, 1'b1);
    offer(3'd1, 16'd4);
    for (int i = 1; i <= 4; i++) begin
      step();
      cmd_valid = 1'b0;
      chk_out($sformatf("fwdB.run%0d", i), 4'b1010, 1'b1, 1'b0);
    end
    step();
    chk_out("fwdB.done", 4'b1010, 1'b0, 1'b1);

    // LEFT dur=0 over FWD: dead time, then exactly one drive cycle
    offer(3'd3, 16'd0);
    for (int i = 1; i <= 8; i++) begin
      step();
      cmd_valid = 1'b0;
      chk_out($sformatf("left.dead%0d", i), 4'b0000, 1'b1, 1'b0);
    end
    step();
    chk_out("left.run1", 4'b1000, 1'b1, 1'b0);
    step();
    chk_out("left.done", 4'b1000, 1'b0, 1'b1);

    // STOP dur=2: coast immediately with no dead time
    offer(3'd0, 16'd2);
    step();
    cmd_valid = 1'b0;
    chk_out("stop.run1", 4'b0000, 1'b1, 1'b0);
    step();
    chk_out("stop.run2", 4'b0000, 1'b1, 1'b0);
    step();
    chk_out("stop.done", 4'b0000, 1'b0, 1'b1);

    // FWD dur=1, then abort during RIGHT's dead time with a command offered
    offer(3'd1, 16'd1);
    step();
    cmd_valid = 1'b0;
    chk_out("fwd1.run1", 4'b1010, 1'b1, 1'b0);
    step();
    chk_out("fwd1.done", 4'b1010, 1'b0, 1'b1);
    offer(3'd4, 16'd3);
    step();
    cmd_valid = 1'b0;
    chk_out("right.dead1", 4'b0000, 1'b1, 1'b0);
    step();
    chk_out("right.dead2", 4'b0000, 1'b1, 1'b0);
    abort = 1'b1;
    offer(3'd2, 16'd5);
    #1;
    check("abort.ready_dead", 16'(cmd_ready), 16'd0);
    step();
    chk_out("abort.e1", 4'b0000, 1'b0, 1'b0);
    check("abort.ready_idle", 16'(cmd_ready), 16'd0);
    step();
    chk_out("abort.e2", 4'b0000, 1'b0, 1'b0);
    abort     = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("abort.ready_rel", 16'(cmd_ready), 16'd1);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk_out($sformatf("abort.quiet%0d", i), 4'b0000, 1'b0, 1'b0);
    end

    // Reserved opcode with a live pattern: err pulse, then done pulse, dir_out unchanged
    offer(3'd1, 16'd1);
    step();
    cmd_valid = 1'b0;
    step();
    chk_out("fwd1b.done", 4'b1010, 1'b0, 1'b1);
    offer(3'd7, 16'd3);
    step();
    cmd_valid = 1'b0;
    chk_out("op7.e1", 4'b1010, 1'b0, 1'b0);
    check("op7.err1", 16'(err), 16'd1);
    step();
    chk_out("op7.e2", 4'b1010, 1'b0, 1'b1);
    check("op7.err2", 16'(err), 16'd0);
    step();
    chk_out("op7.e3", 4'b1010, 1'b0, 1'b0);

    // FWD dur=10 (same pattern, no dead time), then asynchronous reset mid-RUN
    offer(3'd1, 16'd10);
    step();
    cmd_valid = 1'b0;
    chk_out("fwd10.run1", 4'b1010, 1'b1, 1'b0);
    step();
    step();
    chk_out("fwd10.run3", 4'b1010, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 4'b0000, 1'b0, 1'b0);
    check("async_rst.ready", 16'(cmd_ready), 16'd0);
    step();
    rst_n = 1'b1;
    step();
    chk_out("after_rst", 4'b0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/motor_cmd_sequencer.md
Name: motor_cmd_sequencer

Overview:
Issues timed drive segments to the H-bridge decoder. It turns opcode/duration commands into the 4-bit direction pattern {In1,In2,In3,In4} that the decoder consumes. When the active pattern changes, it inserts a dead-time interval of all-zero (coast) so the bridge never switches directly between drive states. It sits between the top-level control logic (buttons, line sensors, host) and the motor decoder, on the same clock.

Parameters:
DUR_W, 16, width of the segment duration field in clock cycles
DEAD_CYCLES, 8, coast cycles inserted before a pattern change (legal range 1..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  opcode (see Behaviour)
cmd_dur  input  DUR_W  segment length in cycles; 0 is treated as 1
abort  input  1  synchronous emergency stop
dir_out  output  4  {In1,In2,In3,In4} pattern to the motor decoder
busy  output  1  high in DEAD or RUN
done  output  1  one-cycle pulse when a segment completes
err  output  1  one-cycle pulse when a reserved opcode is accepted

Behaviour:
- Reset (rst_n low, asynchronous):
  - dir_out=4'b0000, state=IDLE, done=0, err=0, busy=0.
  - cmd_ready=0 while rst_n is low.
- Opcode map to pattern:
  - 0 STOP=0000
  - 1 FWD=1010
  - 2 REV=0101
  - 3 LEFT=1000
  - 4 RIGHT=0010
  - 5 REV_LEFT=0100
  - 6 REV_RIGHT=0001
  - 7 reserved.
- cmd_ready = (state==IDLE) && !abort, combinational. A command is accepted on a rising edge where cmd_valid && cmd_ready.
- States: IDLE, DEAD, RUN. busy = (state!=IDLE).
- Accept in IDLE, with new pattern P and current dir_out C:
  - op 7: err=1 for one cycle and done=1 for one cycle on the following cycle. dir_out is unchanged and the state stays IDLE.
  - C!=0000 and P!=C and P!=0000: dead time is required.
    - dir_out<=0000, state->DEAD, dead counter loaded with DEAD_CYCLES-1.
  - Otherwise (C==0000, or P==C, or P==0000): no dead time.
    - dir_out<=P, state->RUN, run counter loaded with max(cmd_dur,1)-1.
- DEAD:
  - dir_out held at 0000.
  - The counter decrements each edge. On the edge where it is 0: dir_out<=P, state->RUN, run counter loaded.
  - Exactly DEAD_CYCLES cycles of 0000 appear on dir_out.
- RUN:
  - dir_out held at P.
  - The counter decrements each edge. On the edge where it is 0: state->IDLE and done=1 for exactly one cycle.
  - dir_out keeps P after RUN. The motor continues until a new command arrives. STOP is the only way to reach 0000 without abort.
- Latency from accept to pattern:
  - No dead time: 1 edge.
  - With dead time: DEAD_CYCLES+1 edges.
- RUN duration: exactly max(cmd_dur,1) cycles, from pattern applied to IDLE.
- Back-to-back: a new command may be accepted on the first IDLE cycle (the same cycle done is high). The P==C rule gives seamless continuation with no zero gap.
- abort (synchronous, highest priority):
  - From any state, on the next edge: dir_out<=0000 and state->IDLE.
  - Counters are cleared. done and err are not pulsed.
  - A command presented in the same cycle is not accepted.
- Reset mid-operation: immediate return to reset values. No pending command is remembered.
- Counters use no wrap-around. Each counter only decrements from its loaded value to 0.

Test Plan:
- Reset, then FWD with dur=5 -> dir_out=1010 one edge after accept, held 5 cycles. done pulses once. cmd_ready returns high. dir_out stays 1010.
- While FWD active, accept REV with dur=3 (DEAD_CYCLES=8) -> dir_out=0000 for 8 cycles, then 0101 for 3 cycles, then done.
- FWD dur=4, then FWD dur=4 accepted in the done cycle -> dir_out stays 1010 for 8 contiguous cycles with no 0000 gap. done pulses twice.
- LEFT with dur=0 -> 1000 for exactly 1 cycle, then done. Then STOP with dur=2 -> 0000 immediately with no dead time, done after 2 cycles.
- Assert abort during the DEAD phase of RIGHT after FWD -> dir_out=0000 next edge, state IDLE, no done. A simultaneous cmd_valid is ignored (cmd_ready=0).
- Accept op 7 -> err pulse, then done pulse. dir_out unchanged. Then drop rst_n mid-RUN -> dir_out=0000 asynchronously, busy=0.
